// File: rtl/layer_sequencer_if.sv
// Datapath control pins and result write port between layer_sequencer (master) and the MAC datapath (slave).
interface layer_sequencer_if #(
  parameter int N = 4,
  parameter int D = 8
);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int WW = (N * D > 1) ? $clog2(N * D) : 1;

  logic          x_rd_en;
  logic [DW-1:0] x_addr;
  logic          w_rd_en;
  logic [WW-1:0] w_addr;
  logic          acc_clear;
  logic          acc_en;
  logic          res_valid;
  logic [NW-1:0] res_addr;
  logic          res_ready;

  modport master (
    output x_rd_en, x_addr, w_rd_en, w_addr, acc_clear, acc_en, res_valid, res_addr,
    input  res_ready
  );

  modport slave (
    input  x_rd_en, x_addr, w_rd_en, w_addr, acc_clear, acc_en, res_valid, res_addr,
    output res_ready
  );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer for the single-MAC datapath: N neurons x D elements.
// Optional LAYER_SEQ_ABORT_EN adds an abort input that drops back to IDLE from any busy state.
module layer_sequencer #(
  parameter int N = 4,
  parameter int D = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  layer_sequencer_if.master bus
`ifdef LAYER_SEQ_ABORT_EN
  ,
  input  logic abort
`endif
);
  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int WW = (N * D > 1) ? $clog2(N * D) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    READ,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t        state;
  logic [NW-1:0] j;
  logic [DW-1:0] k;
  logic          abort_hit;

`ifdef LAYER_SEQ_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign bus.x_addr   = k;
  assign bus.res_addr = j;

  // Outputs are set on the edge that enters each state, so every pin is a flop.
  // acc_en trails x_rd_en by one cycle to match the memory read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      j             <= '0;
      k             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.x_rd_en   <= 1'b0;
      bus.w_rd_en   <= 1'b0;
      bus.w_addr    <= '0;
      bus.acc_clear <= 1'b0;
      bus.acc_en    <= 1'b0;
      bus.res_valid <= 1'b0;
    end else begin
      bus.acc_en    <= bus.x_rd_en;
      bus.acc_clear <= 1'b0;
      done          <= 1'b0;
      if (abort_hit) begin
        state         <= IDLE;
        j             <= '0;
        k             <= '0;
        busy          <= 1'b0;
        bus.x_rd_en   <= 1'b0;
        bus.w_rd_en   <= 1'b0;
        bus.acc_clear <= 1'b1;
        bus.acc_en    <= 1'b0;
        bus.res_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state         <= CLEAR;
              busy          <= 1'b1;
              bus.acc_clear <= 1'b1;
              k             <= '0;
            end
          end
          CLEAR: begin
            state       <= READ;
            k           <= '0;
            bus.x_rd_en <= 1'b1;
            bus.w_rd_en <= 1'b1;
            bus.w_addr  <= WW'(j) * WW'(D);
          end
          READ: begin
            // k resets explicitly at D-1 so non-power-of-two D never relies on wrap.
            if (k == DW'(D - 1)) begin
              state       <= DRAIN;
              k           <= '0;
              bus.x_rd_en <= 1'b0;
              bus.w_rd_en <= 1'b0;
            end else begin
              k          <= k + 1'b1;
              bus.w_addr <= bus.w_addr + 1'b1;
            end
          end
          DRAIN: begin
            state         <= WRITE;
            bus.res_valid <= 1'b1;
          end
          WRITE: begin
            if (bus.res_ready) begin
              bus.res_valid <= 1'b0;
              if (j == NW'(N - 1)) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                j             <= j + 1'b1;
                state         <= CLEAR;
                bus.acc_clear <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            j     <= '0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Sequences one fully-connected layer on the shared single-MAC datapath: x memory, w memory, accumulator and result register file. For each of N output neurons it clears the accumulator and streams D x/w element pairs through the MAC. It then offers the accumulated result on a valid/ready write port. It sits between the top-level start/done handshake and the datapath control pins.

Parameters:
N, 4, number of output neurons (N >= 1)
D, 8, vector length per neuron (D >= 2)
NW, $clog2(N) (minimum 1), neuron index width (localparam)
DW, $clog2(D) (minimum 1), element index width (localparam)
WW, $clog2(N*D) (minimum 1), weight address width (localparam)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin layer; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when layer completes
x_rd_en  output  1  x memory read strobe
x_addr  output  DW  x element index k
w_rd_en  output  1  w memory read strobe
w_addr  output  WW  weight address j*D+k
acc_clear  output  1  zero the accumulator
acc_en  output  1  accumulate the x*w product returned by memory
res_valid  output  1  result for neuron res_addr is ready
res_addr  output  NW  neuron index j
res_ready  input  1  result sink accepts this cycle

Behaviour:
- Reset (rst=0, async): state IDLE; j=0, k=0; all outputs 0 immediately, including addresses.
- Memory read latency is 1 cycle, so acc_en is a registered copy of x_rd_en.
- FSM states:
  - IDLE: start=1 -> CLEAR. start=0 -> stay.
  - CLEAR: acc_clear=1 for one cycle; k<=0 -> READ.
  - READ: x_rd_en=w_rd_en=1; x_addr=k; w_addr=j*D+k. k increments each cycle; when k==D-1 -> DRAIN.
  - DRAIN: rd_en=0; acc_en=1 for the last element -> WRITE.
  - WRITE: res_valid=1, res_addr=j, held stable until res_ready=1.
    - On handshake with j==N-1 -> DONE.
    - On handshake otherwise: j<=j+1 -> CLEAR.
  - DONE: done=1 for one cycle; j<=0 -> IDLE.
- acc_en is high for exactly D cycles per neuron: the last D-1 READ cycles plus DRAIN.
- acc_en is never high in the same cycle as acc_clear.
- Latency with res_ready tied 1: D+3 cycles per neuron. done is asserted in cycle N*(D+3)+1 after the edge that samples start.
- Each cycle res_ready is held low adds exactly one cycle. During that wait no reads, acc_en or acc_clear are issued.
- start while busy=1: ignored, no restart and no counter change. start in the DONE cycle: ignored.
- res_ready while res_valid=0: ignored.
- Counters wrap only via explicit reset to 0: k at D-1, j at N-1. No modulo arithmetic on non-power-of-2 N or D.
- w_addr is computed as j*D+k in WW bits and never overflows, since the maximum is N*D-1.
- Reset asserted mid-operation: abandons the layer; no done, no res_valid. The next start begins at neuron 0.
- All outputs are registered (Moore); no combinational path from inputs to outputs.

Optional Feature:
Macro LAYER_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in any non-IDLE state: next state IDLE; acc_clear=1 for that one cycle; rd_en, acc_en and res_valid forced 0 from that edge; j,k<=0; done not pulsed.
  - abort in IDLE: ignored.
  - abort has priority over res_ready handshake and start.
- Undefined: no abort port; a layer always runs to done or reset.

Test Plan:
1. Reset: rst=0 with random inputs -> all outputs 0, busy=0. Release; with no start for 10 cycles -> outputs stay 0.
2. Nominal run (N=4, D=8, res_ready=1): start pulse -> w_addr sequence 0..31 and x_addr 0..7 repeated 4 times; 32 acc_en pulses; 4 acc_clear pulses; res_addr 0,1,2,3; done at cycle 45; busy falls the cycle after done.
3. Backpressure: res_ready=0 for 5 cycles while res_addr=1 -> res_valid and res_addr=1 held stable; no rd_en or acc_en; done at cycle 50.
4. Spurious start: start held high throughout the run -> exactly one layer executes. A new layer begins only after returning to IDLE, at cycle 46 or later.
5. Reset mid-run: rst=0 during READ of neuron 2, k=3 -> outputs 0 immediately, no done. A fresh start reproduces scenario 2 exactly.
6. LAYER_SEQ_ABORT_EN: abort=1 during READ of neuron 1 -> next cycle IDLE with acc_clear=1 and busy=0; no res_valid for neuron 1; no done. A following start begins at w_addr=0.
